flags_stack: RTL and testbench
==============================

# flags_stack

Parametrised successor to the Nibbler two-bit flags register. Holds `NUM_FLAGS` condition flags with per-bit load masking, and adds a hardware save/restore stack of depth `STACK_DEPTH`. The stack lets the control unit push flags on call/interrupt entry and pop them on return. It sits between the ALU flag outputs and the control ROM's condition inputs.

## Interface
Parameters:
- `NUM_FLAGS`, default 2: number of flag bits; must be ≥1.
- `STACK_DEPTH`, default 4: number of save entries; must be ≥2.
- `RESET_VALUE`, default 0: value of `flagsOut` after reset; `NUM_FLAGS` bits wide.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `notReset`, in, 1: asynchronous, active-low reset.
- `flagsIn`, in, `NUM_FLAGS`: new flag values from the ALU, stored as presented with no inversion.
- `load`, in, 1: flag load strobe.
- `loadMask`, in, `NUM_FLAGS`: per-bit load enable, qualified by `load`.
- `push`, in, 1: save the current `flagsOut` onto the stack.
- `pop`, in, 1: restore `flagsOut` from the top of the stack.
- `errClr`, in, 1: clears `stackErr`.
- `flagsOut`, out, `NUM_FLAGS`: registered flags.
- `stackCount`, out, `$clog2(STACK_DEPTH+1)`: number of occupied entries.
- `stackEmpty`, out, 1: asserted when `stackCount == 0`.
- `stackFull`, out, 1: asserted when `stackCount == STACK_DEPTH`.
- `stackErr`, out, 1: sticky overflow/underflow indicator.

## Operation
- **State:** `flagsOut` register, stack array `STACK_DEPTH × NUM_FLAGS`, stack pointer `sp` (equals `stackCount`), and `stackErr`.
- **Valid push:** `push && !stackFull`. Writes the pre-edge `flagsOut` to `stack[sp]`; then `sp <= sp+1`.
- **Valid pop:** `pop && !stackEmpty`. Loads `flagsOut <= stack[sp-1]`, replacing all bits; then `sp <= sp-1`.
- **Flag priority:**
  - A valid pop overrides `load` entirely.
  - Otherwise, each bit `i` loads `flagsIn[i]` when `load && loadMask[i]`, and holds its value when not.
- **Push with load:** the pushed value is the pre-load flags, and `flagsOut` takes the loaded value. This is the interrupt-entry case.
- **Push and pop together, stack not empty:** swap. `flagsOut <= stack[sp-1]`, `stack[sp-1] <= old flagsOut`, and `sp` is unchanged. This applies even when the stack is full.
- **Push and pop together, stack empty:** the pop is an underflow. The push proceeds, `sp <= 1`, `load` applies, and `stackErr` is set.
- **Overflow:** a push while full with no pop is ignored (no write, `sp` held) and sets `stackErr`.
- **Underflow:** a pop while empty is ignored; `load` still applies and `stackErr` is set.
- **Error clear:** `stackErr` clears on `errClr` unless a new error occurs in the same cycle. A new error wins.
- **Stack contents** are not reset; entries at or above `sp` are don't-care.

## Timing
- All outputs are registered or decoded from registered `sp`. Updates take effect one cycle after the strobe, with no combinational path from input to output.
- Reset values: `flagsOut = RESET_VALUE`, `stackCount = 0`, `stackEmpty = 1`, `stackFull = 0`, `stackErr = 0`.
- Asserting `notReset` low mid-operation clears state immediately, without waiting for a clock edge. The stack is discarded because `sp` returns to 0.
- A popped value is visible on `flagsOut` the cycle after `pop`. Back-to-back push/pop on consecutive cycles is supported at full rate.

## Configuration
- **`FLAGS_STACK_EN` defined:** the stack, `sp`, and the full push/pop/error behaviour above are compiled in.
- **`FLAGS_STACK_EN` undefined:** no stack storage is built.
  - `push`, `pop` and `errClr` are ignored.
  - Outputs are tied off: `stackCount = 0`, `stackEmpty = 1`, `stackFull = 0`, `stackErr = 0`.
  - The block reduces to a masked-load flags register.

## Test plan
All scenarios use `NUM_FLAGS=2` and `STACK_DEPTH=4`.
- **Reset:** hold `notReset` low mid-stream with `flagsOut=2'b11` and `sp=3`. Expect immediately `flagsOut=00`, `stackCount=0`, `stackEmpty=1`, `stackErr=0`.
- **Masked load:** start at `flagsOut=00`; `load=1`, `loadMask=10`, `flagsIn=11`. Next cycle expect `flagsOut=10`. Then `load=0` with `flagsIn=01`: expect `flagsOut` holds `10`.
- **Interrupt entry/exit:** `flagsOut=01`; `push=1` with `load=1`, `loadMask=11`, `flagsIn=10`. Expect `flagsOut=10`, `stackCount=1`. Then `pop`: expect `flagsOut=01`, `stackCount=0`, `stackEmpty=1`.
- **Overflow and sticky error:**
  - Push values 00, 01, 10, 11; expect `stackFull=1`.
  - A fifth push: `stackCount` stays 4 and `stackErr=1`.
  - Pop four times: expect 11, 10, 01, 00 in that order.
  - A fifth pop: `stackErr` stays 1 and `flagsOut` holds `00`.
  - `errClr`: next cycle `stackErr=0`.
- **Swap:** stack holds `[10]`, `flagsOut=01`; `push=1`, `pop=1`. Expect `flagsOut=10`, top entry `01`, `stackCount=1`.
- **Error priority:** underflow pop with `errClr=1` in the same cycle. Expect `stackErr=1`.

Source files
------------

// File: rtl/flags_stack.sv
// flags_stack: masked-load condition flags with an optional save/restore stack (enabled by `FLAGS_STACK_EN`).
// Latency: all outputs are registered or decoded from registered sp; every update is visible one cycle after its strobe.
// Backpressure: none; overflowing pushes and underflowing pops are dropped and raise the sticky stackErr flag.
module flags_stack #(
    parameter int                   NUM_FLAGS   = 2,
    parameter int                   STACK_DEPTH = 4,
    parameter logic [NUM_FLAGS-1:0] RESET_VALUE = '0
) (
    input  logic                               clk,
    input  logic                               notReset,
    input  logic [NUM_FLAGS-1:0]               flagsIn,
    input  logic                               load,
    input  logic [NUM_FLAGS-1:0]               loadMask,
    input  logic                               push,
    input  logic                               pop,
    input  logic                               errClr,
    output logic [NUM_FLAGS-1:0]               flagsOut,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stackCount,
    output logic                               stackEmpty,
    output logic                               stackFull,
    output logic                               stackErr
);

    logic [NUM_FLAGS-1:0] masked;

    assign masked = load ? ((flagsOut & ~loadMask) | (flagsIn & loadMask)) : flagsOut;

`ifdef FLAGS_STACK_EN
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [NUM_FLAGS-1:0] stack_mem [STACK_DEPTH];
    logic [CW-1:0]        sp;
    logic [CW-1:0]        sp_nxt;
    logic [CW-1:0]        sp_m1;
    logic [AW-1:0]        wr_idx;
    logic [AW-1:0]        top_idx;
    logic                 stk_empty;
    logic                 stk_full;
    logic                 pop_ok;
    logic                 push_ok;
    logic                 swap;
    logic                 err_new;
    logic [NUM_FLAGS-1:0] flags_nxt;

    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == CW'(STACK_DEPTH));
    assign sp_m1     = sp - CW'(1);
    assign wr_idx    = sp[AW-1:0];
    assign top_idx   = sp_m1[AW-1:0];

    // push+pop on a non-empty stack is a swap, which is legal even when full
    assign pop_ok  = pop && !stk_empty;
    assign swap    = push && pop_ok;
    assign push_ok = push && !pop_ok && !stk_full;
    assign err_new = (pop && stk_empty) || (push && !pop && stk_full);

    always_comb begin
        flags_nxt = pop_ok ? stack_mem[top_idx] : masked;
        sp_nxt    = sp;
        if (push_ok) begin
            sp_nxt = sp + CW'(1);
        end else if (pop_ok && !swap) begin
            sp_nxt = sp_m1;
        end
    end

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            flagsOut <= RESET_VALUE;
            sp       <= '0;
            stackErr <= 1'b0;
        end else begin
            flagsOut <= flags_nxt;
            sp       <= sp_nxt;
            if (err_new) begin
                stackErr <= 1'b1;
            end else if (errClr) begin
                stackErr <= 1'b0;
            end
        end
    end

    // Storage is not reset: entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (swap) begin
            stack_mem[top_idx] <= flagsOut;
        end else if (push_ok) begin
            stack_mem[wr_idx] <= flagsOut;
        end
    end

    assign stackCount = sp;
    assign stackEmpty = stk_empty;
    assign stackFull  = stk_full;
`else
    logic unused_stack_in;

    assign unused_stack_in = &{1'b0, push, pop, errClr};

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            flagsOut <= RESET_VALUE;
        end else begin
            flagsOut <= masked;
        end
    end

    assign stackCount = '0;
    assign stackEmpty = 1'b1;
    assign stackFull  = 1'b0;
    assign stackErr   = 1'b0;
`endif

endmodule

// File: tb/tb_flags_stack.sv
// Scoreboard bench for flags_stack; follows the stack or plain-register behaviour depending on FLAGS_STACK_EN.
module tb_flags_stack;

    localparam int NF = 2;
    localparam int SD = 4;
`ifdef FLAGS_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic          clk;
    logic          notReset;
    logic [NF-1:0] flagsIn;
    logic          load;
    logic [NF-1:0] loadMask;
    logic          push;
    logic          pop;
    logic          errClr;
    logic [NF-1:0] flagsOut;
    logic [2:0]    stackCount;
    logic          stackEmpty;
    logic          stackFull;
    logic          stackErr;

    flags_stack #(
        .NUM_FLAGS   (NF),
        .STACK_DEPTH (SD),
        .RESET_VALUE (2'b00)
    ) dut (
        .clk        (clk),
        .notReset   (notReset),
        .flagsIn    (flagsIn),
        .load       (load),
        .loadMask   (loadMask),
        .push       (push),
        .pop        (pop),
        .errClr     (errClr),
        .flagsOut   (flagsOut),
        .stackCount (stackCount),
        .stackEmpty (stackEmpty),
        .stackFull  (stackFull),
        .stackErr   (stackErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] flags;
        logic [2:0] cnt;
        logic       empty;
        logic       full;
        logic       err;
    } out_t;

    typedef struct {
        string name;
        out_t  v;
    } ent_t;

    ent_t exp_q[$];
    out_t obs_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    logic [1:0] m_flags;
    int         m_sp;
    logic [1:0] m_stk [SD];
    logic       m_err;

    function automatic out_t sample();
        out_t o;
        o = {flagsOut, stackCount, stackEmpty, stackFull, stackErr};
        return o;
    endfunction

    task automatic model_reset();
        m_flags = 2'b00;
        m_sp    = 0;
        m_err   = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue the model's prediction, capture the DUT after the edge.
    task automatic cycle(input string nm, input logic [1:0] fi, input logic ld, input logic [1:0] lm,
                         input logic ps, input logic pp, input logic ec);
        out_t       e;
        logic [1:0] nf;
        logic       pop_ok;
        logic       full;
        logic       errn;
        flagsIn  = fi;
        load     = ld;
        loadMask = lm;
        push     = ps;
        pop      = pp;
        errClr   = ec;
        nf = ld ? ((m_flags & ~lm) | (fi & lm)) : m_flags;
        if (STK) begin
            full   = (m_sp == SD);
            pop_ok = pp && (m_sp != 0);
            errn   = (pp && m_sp == 0) || (ps && !pp && full);
            if (pop_ok) nf = m_stk[m_sp-1];
            if (ps && pop_ok) begin
                m_stk[m_sp-1] = m_flags;
            end else if (ps && !full) begin
                m_stk[m_sp] = m_flags;
                m_sp++;
            end else if (pop_ok) begin
                m_sp--;
            end
            m_err = errn ? 1'b1 : (ec ? 1'b0 : m_err);
        end
        m_flags = nf;
        e.flags = m_flags;
        e.cnt   = 3'(m_sp);
        e.empty = (m_sp == 0);
        e.full  = (m_sp == SD);
        e.err   = m_err;
        exp_q.push_back('{nm, e});
        @(posedge clk);
        #1;
        obs_q.push_back(sample());
        push   = 1'b0;
        pop    = 1'b0;
        errClr = 1'b0;
        load   = 1'b0;
    endtask

    task automatic test_reset();
        notReset = 1'b1;
        flagsIn  = '0;
        load     = 1'b0;
        loadMask = '0;
        push     = 1'b0;
        pop      = 1'b0;
        errClr   = 1'b0;
        #1 notReset = 1'b0;
        #11;
        total++;
        if (sample() !== 8'b00_000_1_0_0) begin
            bad++;
            $display("FAIL reset_state: got %b want %b", sample(), 8'b00_000_1_0_0);
        end
        model_reset();
        @(negedge clk);
        notReset = 1'b1;
    endtask

    task automatic test_masked_load();
        cycle("mask_load", 2'b11, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        total++;
        if (flagsOut !== 2'b10) begin
            bad++;
            $display("FAIL mask_load_flags: got %b want %b", flagsOut, 2'b10);
        end
        cycle("mask_hold", 2'b01, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        total++;
        if (flagsOut !== 2'b10) begin
            bad++;
            $display("FAIL mask_hold_flags: got %b want %b", flagsOut, 2'b10);
        end
        while (exp_q.size() != 0) begin
            ent_t e;
            out_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_interrupt();
        cycle("irq_set01", 2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cycle("irq_entry", 2'b10, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        total++;
        if (flagsOut !== 2'b10) begin
            bad++;
            $display("FAIL irq_entry_flags: got %b want %b", flagsOut, 2'b10);
        end
        cycle("irq_exit", 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        while (exp_q.size() != 0) begin
            ent_t e;
            out_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_overflow();
        cycle("ovf_set00", 2'b00, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cycle("ovf_push00", 2'b01, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        cycle("ovf_push01", 2'b10, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        cycle("ovf_push10", 2'b11, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        cycle("ovf_push11", 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        total++;
        if (stackFull !== STK) begin
            bad++;
            $display("FAIL ovf_full: got %b want %b", stackFull, STK);
        end
        cycle("ovf_push5", 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        total++;
        if (stackErr !== STK) begin
            bad++;
            $display("FAIL ovf_err: got %b want %b", stackErr, STK);
        end
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("ovf_pop%0d", i + 1), 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        end
        cycle("ovf_errclr", 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        total++;
        if (stackErr !== 1'b0) begin
            bad++;
            $display("FAIL ovf_errclr: got %b want %b", stackErr, 1'b0);
        end
        while (exp_q.size() != 0) begin
            ent_t e;
            out_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_swap();
        cycle("swap_set10", 2'b10, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cycle("swap_push", 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        cycle("swap_set01", 2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        cycle("swap", 2'b11, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        total++;
        if (flagsOut !== (STK ? 2'b10 : 2'b11)) begin
            bad++;
            $display("FAIL swap_flags: got %b want %b", flagsOut, (STK ? 2'b10 : 2'b11));
        end
        cycle("swap_pop_top", 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        while (exp_q.size() != 0) begin
            ent_t e;
            out_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_err_priority();
        cycle("prio_underflow_clr", 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        total++;
        if (stackErr !== STK) begin
            bad++;
            $display("FAIL prio_err: got %b want %b", stackErr, STK);
        end
        cycle("prio_clr", 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        cycle("prio_pushpop_empty", 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        cycle("prio_clr2", 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        while (exp_q.size() != 0) begin
            ent_t e;
            out_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            cycle($sformatf("b2b_push%0d", i), 2'(i), 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        end
        cycle("b2b_swap_full", 2'b00, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) begin
            cycle($sformatf("b2b_rand%0d", i), 2'($urandom_range(3)), 1'($urandom_range(1)),
                  2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  ($urandom_range(7) == 0));
        end
        while (exp_q.size() != 0) begin
            ent_t e;
            out_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            cycle("rst_drain", 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        end
        cycle("rst_set11", 2'b11, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("rst_push%0d", i), 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        end
        while (exp_q.size() != 0) begin
            ent_t e;
            out_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, o, e.v);
            end
        end
        #2 notReset = 1'b0;
        #1;
        total++;
        if (sample() !== 8'b00_000_1_0_0) begin
            bad++;
            $display("FAIL reset_mid: got %b want %b", sample(), 8'b00_000_1_0_0);
        end
        model_reset();
        @(negedge clk);
        notReset = 1'b1;
        cycle("rst_after_pop", 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        cycle("rst_after_load", 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        while (exp_q.size() != 0) begin
            ent_t e;
            out_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.name, o, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_masked_load();
        test_interrupt();
        test_overflow();
        test_swap();
        test_err_priority();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
